// File: rtl/aes_spi_slave_frame_if.sv
// Bundle of signals between the SPI framing stage, the SPI master and the AES core.
// Parameters:
//   nb - block size in 32-bit words (MSG_W = 32*nb)
//   nr - round count (KEY_W = 32*nb*(nr+1))
// Signals:
//   cs_enc_dec, Mosi        : SPI select (active-low) and serial data from the master
//   Miso, Out_clk           : serial result to the master and its bit-valid qualifier
//   core_msg, core_key      : parallel message / expanded key to the core
//   core_start              : one-cycle start pulse to the core
//   core_done, core_result  : result-valid pulse and result block from the core
//   err                     : sticky error flag
// Modports:
//   slave  - the framing stage
//   master - the surrounding environment (SPI master + core)
interface aes_spi_slave_frame_if #(
    parameter int unsigned nb = 4,
    parameter int unsigned nr = 14
);
    localparam int unsigned MSG_W = 32 * nb;
    localparam int unsigned KEY_W = 32 * nb * (nr + 1);

    logic             cs_enc_dec;
    logic             Mosi;
    logic             Miso;
    logic             Out_clk;
    logic [MSG_W-1:0] core_msg;
    logic [KEY_W-1:0] core_key;
    logic             core_start;
    logic             core_done;
    logic [MSG_W-1:0] core_result;
    logic             err;

    modport slave (
        input  cs_enc_dec,
        input  Mosi,
        input  core_done,
        input  core_result,
        output Miso,
        output Out_clk,
        output core_msg,
        output core_key,
        output core_start,
        output err
    );

    modport master (
        output cs_enc_dec,
        output Mosi,
        output core_done,
        output core_result,
        input  Miso,
        input  Out_clk,
        input  core_msg,
        input  core_key,
        input  core_start,
        input  err
    );
endinterface

// File: rtl/aes_spi_slave_frame.sv
// SPI slave framing stage between the SPI master and the AES core.
// Receives one serial frame {message, expanded key} MSB first on Mosi, hands both words
// to the core with a one-cycle start pulse, waits for the core result and shifts it
// back out on Miso (MSB first) qualified by Out_clk.
// Ports:
//   in_clk - system clock (the master drives Mosi from this clock)
//   rst_n  - asynchronous active-low reset
//   bus    - aes_spi_slave_frame_if.slave (SPI pins, core handshake, err)
// Optional feature: define FRAME_PARITY_EN to append one even-parity bit to each frame;
// a parity mismatch suppresses core_start and sets err.
module aes_spi_slave_frame #(
    parameter int unsigned nk      = 8,
    parameter int unsigned nb      = 4,
    parameter int unsigned nr      = 14,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  in_clk,
    input  logic                  rst_n,
    aes_spi_slave_frame_if.slave  bus
);

    localparam int unsigned MSG_W   = 32 * nb;
    localparam int unsigned KEY_W   = 32 * nb * (nr + 1);
    localparam int unsigned FRAME_W = MSG_W + KEY_W;
`ifdef FRAME_PARITY_EN
    localparam int unsigned RX_LEN  = FRAME_W + 1;
`else
    localparam int unsigned RX_LEN  = FRAME_W;
`endif
    localparam int unsigned RX_CW   = $clog2(RX_LEN + 1);
    localparam int unsigned WAIT_CW = $clog2(TIMEOUT + 1);
    localparam int unsigned TX_CW   = $clog2(MSG_W + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RX    = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_TX    = 3'd4;

    // nk only has to agree with the AES variant selected by nr
    if ((nk != 4 && nk != 6 && nk != 8) || (nr != nk + 6)) begin : g_bad_cfg
        $error("aes_spi_slave_frame: inconsistent nk/nr configuration");
    end

    logic [2:0]         state_q,      state_d;
    logic [FRAME_W-1:0] sr_q,         sr_d;
    logic [RX_CW-1:0]   rx_cnt_q,     rx_cnt_d;
    logic [WAIT_CW-1:0] wait_cnt_q,   wait_cnt_d;
    logic [TX_CW-1:0]   tx_cnt_q,     tx_cnt_d;
    logic [MSG_W-1:0]   tx_sr_q,      tx_sr_d;
    logic               armed_q,      armed_d;
    logic               miso_q,       miso_d;
    logic               out_clk_q,    out_clk_d;
    logic [MSG_W-1:0]   core_msg_q,   core_msg_d;
    logic [KEY_W-1:0]   core_key_q,   core_key_d;
    logic               core_start_q, core_start_d;
    logic               err_q,        err_d;
`ifdef FRAME_PARITY_EN
    logic               par_q,        par_d;
`endif

    // Receive shift register with the current Mosi bit appended
    logic [FRAME_W-1:0] sr_shift_c;
    assign sr_shift_c = {sr_q[FRAME_W-2:0], bus.Mosi};

    // State register and all registered outputs
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            rx_cnt_q     <= '0;
            wait_cnt_q   <= '0;
            tx_cnt_q     <= '0;
            tx_sr_q      <= '0;
            armed_q      <= 1'b1;
            miso_q       <= 1'b0;
            out_clk_q    <= 1'b0;
            core_msg_q   <= '0;
            core_key_q   <= '0;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef FRAME_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            rx_cnt_q     <= rx_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_sr_q      <= tx_sr_d;
            armed_q      <= armed_d;
            miso_q       <= miso_d;
            out_clk_q    <= out_clk_d;
            core_msg_q   <= core_msg_d;
            core_key_q   <= core_key_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
`ifdef FRAME_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        rx_cnt_d     = rx_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        tx_cnt_d     = tx_cnt_q;
        tx_sr_d      = tx_sr_q;
        armed_d      = armed_q;
        miso_d       = miso_q;
        out_clk_d    = out_clk_q;
        core_msg_d   = core_msg_q;
        core_key_d   = core_key_q;
        core_start_d = 1'b0;
        err_d        = err_q;
`ifdef FRAME_PARITY_EN
        par_d        = par_q;
`endif

        // Seeing the select deasserted re-arms reception for the next frame
        if (bus.cs_enc_dec) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !bus.cs_enc_dec) begin
                    sr_d     = sr_shift_c;
                    rx_cnt_d = RX_CW'(1);
`ifdef FRAME_PARITY_EN
                    par_d    = bus.Mosi;
`endif
                    state_d  = ST_RX;
                end
            end

            ST_RX: begin
                if (bus.cs_enc_dec) begin
                    // Short frame: drop it, keep core outputs and err as they are
                    rx_cnt_d = '0;
                    state_d  = ST_IDLE;
                end else if (rx_cnt_q == RX_CW'(RX_LEN - 1)) begin
                    // This edge samples the final bit of the frame
                    rx_cnt_d = '0;
                    armed_d  = 1'b0;
`ifdef FRAME_PARITY_EN
                    // Final bit is the parity bit; data is already complete in sr_q
                    if (par_q ^ bus.Mosi) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        core_msg_d   = sr_q[FRAME_W-1:KEY_W];
                        core_key_d   = sr_q[KEY_W-1:0];
                        core_start_d = 1'b1;
                        state_d      = ST_START;
                    end
`else
                    // Load the core words together with the start pulse so the core
                    // sees valid data in the same cycle as core_start
                    sr_d         = sr_shift_c;
                    core_msg_d   = sr_shift_c[FRAME_W-1:KEY_W];
                    core_key_d   = sr_shift_c[KEY_W-1:0];
                    core_start_d = 1'b1;
                    state_d      = ST_START;
`endif
                end else begin
                    sr_d     = sr_shift_c;
                    rx_cnt_d = rx_cnt_q + RX_CW'(1);
`ifdef FRAME_PARITY_EN
                    par_d    = par_q ^ bus.Mosi;
`endif
                end
            end

            ST_START: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                // core_done takes priority over a timeout expiring in the same cycle
                if (bus.core_done) begin
                    miso_d     = bus.core_result[MSG_W-1];
                    out_clk_d  = 1'b1;
                    tx_sr_d    = bus.core_result << 1;
                    tx_cnt_d   = '0;
                    wait_cnt_d = '0;
                    state_d    = ST_TX;
                end else if (wait_cnt_q == WAIT_CW'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CW'(1);
                end
            end

            ST_TX: begin
                // tx_cnt_q counts bits already presented before the current one
                if (tx_cnt_q == TX_CW'(MSG_W - 1)) begin
                    miso_d    = 1'b0;
                    out_clk_d = 1'b0;
                    tx_cnt_d  = '0;
                    state_d   = ST_IDLE;
                end else begin
                    miso_d   = tx_sr_q[MSG_W-1];
                    tx_sr_d  = tx_sr_q << 1;
                    tx_cnt_d = tx_cnt_q + TX_CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.Miso       = miso_q;
    assign bus.Out_clk    = out_clk_q;
    assign bus.core_msg   = core_msg_q;
    assign bus.core_key   = core_key_q;
    assign bus.core_start = core_start_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_aes_spi_slave_frame.sv
// Directed bench for aes_spi_slave_frame: nominal frame, result return, aborted frame,
// core timeout, reset during transmit, re-arm rule and (with FRAME_PARITY_EN) parity.
module tb_aes_spi_slave_frame;

    localparam int unsigned MSG_W   = 128;
    localparam int unsigned KEY_W   = 1920;
    localparam int unsigned FRAME_W = MSG_W + KEY_W;
`ifdef FRAME_PARITY_EN
    localparam int unsigned FB = FRAME_W + 1;
`else
    localparam int unsigned FB = FRAME_W;
`endif

    logic in_clk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 in_clk = ~in_clk;

    aes_spi_slave_frame_if bus ();

    aes_spi_slave_frame dut (
        .in_clk (in_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_pass     = 0;
    int n_total    = 0;
    int start_cnt  = 0;
    int oclk_cnt   = 0;

    task automatic chk(input string tag, input logic [MSG_W-1:0] obs, input logic [MSG_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_key(input string tag, input logic [KEY_W-1:0] exp);
        for (int c = 0; c < KEY_W / MSG_W; c++) begin
            chk($sformatf("%s[%0d]", tag, c), bus.core_key[c*MSG_W +: MSG_W], exp[c*MSG_W +: MSG_W]);
        end
    endtask

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge in_clk);
        #1;
        if (bus.core_start === 1'b1) start_cnt++;
        if (bus.Out_clk === 1'b1) oclk_cnt++;
    endtask

    // Clock nbits of the frame with select low; flip inverts one bit (-1 = none)
    task automatic send_bits(input logic [MSG_W-1:0] msg, input logic [KEY_W-1:0] key,
                             input int nbits, input int flip);
        logic [FRAME_W-1:0] frame;
        logic par;
        logic b;
        frame = {msg, key};
        par   = ^frame;
        for (int i = 0; i < nbits; i++) begin
            if (i < int'(FRAME_W)) b = frame[FRAME_W-1-i];
            else b = par;
            if (i == flip) b = ~b;
            bus.cs_enc_dec = 1'b0;
            bus.Mosi       = b;
            tick();
        end
    endtask

    // Sample MSG_W serial bits starting in the current (first TX) cycle
    task automatic capture_tx(output logic [MSG_W-1:0] got, output int n_oc);
        got  = '0;
        n_oc = 0;
        for (int i = 0; i < MSG_W; i++) begin
            if (bus.Out_clk === 1'b1) n_oc++;
            got[MSG_W-1-i] = bus.Miso;
            bus.Mosi = 1'($urandom);
            tick();
        end
    endtask

    logic [MSG_W-1:0] msg1, msg2, msg3, res1, res2, got;
    logic [KEY_W-1:0] key1, key2;
    int               n_oc, s0, o0, waited;

    initial begin
        msg1 = 128'h00112233445566778899aabbccddeeff;
        msg2 = 128'hdeadbeef0123456789abcdeffeedface;
        msg3 = 128'h0123456789abcdeffedcba9876543210;
        res1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        res2 = 128'h3925841d02dc09fbdc118597196a0b32;
        key1 = {240{8'hA5}};
        key2 = {240{8'h3C}};

        bus.cs_enc_dec  = 1'b1;
        bus.Mosi        = 1'b0;
        bus.core_done   = 1'b0;
        bus.core_result = '0;

        // Reset values
        tick();
        tick();
        chk("rst_miso",  128'(bus.Miso), 0);
        chk("rst_oclk",  128'(bus.Out_clk), 0);
        chk("rst_start", 128'(bus.core_start), 0);
        chk("rst_err",   128'(bus.err), 0);
        chk("rst_msg",   bus.core_msg, 0);
        chk("rst_key",   128'(|bus.core_key), 0);
        rst_n = 1'b1;
        tick();

        // Nominal frame: start pulse right after the final bit, words exact
        start_cnt = 0;
        send_bits(msg1, key1, FB, -1);
        chk("nom_start", 128'(bus.core_start), 1);
        chk("nom_start_cnt", 128'(start_cnt), 1);
        chk("nom_msg", bus.core_msg, msg1);
        chk_key("nom_key", key1);
        bus.cs_enc_dec = 1'b1;
        tick();
        chk("nom_start_1cyc", 128'(bus.core_start), 0);

        // Result return: core_done 10 cycles after core_start
        oclk_cnt = 0;
        for (int k = 0; k < 9; k++) tick();
        bus.core_done   = 1'b1;
        bus.core_result = res1;
        tick();
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        chk("ret_oclk_pre", 128'(oclk_cnt), 1);
        chk("ret_first_bit", 128'(bus.Miso), 128'(res1[MSG_W-1]));
        capture_tx(got, n_oc);
        chk("ret_data", got, res1);
        chk("ret_oclk_cnt", 128'(n_oc), 128);
        chk("ret_oclk_after", 128'(bus.Out_clk), 0);
        chk("ret_miso_after", 128'(bus.Miso), 0);
        tick();

        // Aborted frame after 700 bits
        s0 = start_cnt;
        send_bits(msg2, key2, 700, -1);
        bus.cs_enc_dec = 1'b1;
        tick();
        tick();
        chk("abort_no_start", 128'(start_cnt - s0), 0);
        chk("abort_msg_hold", bus.core_msg, msg1);
        chk_key("abort_key_hold", key1);
        chk("abort_err", 128'(bus.err), 0);

        // Following full frame is accepted
        send_bits(msg2, key2, FB, -1);
        chk("after_abort_start", 128'(bus.core_start), 1);
        chk("after_abort_msg", bus.core_msg, msg2);
        chk_key("after_abort_key", key2);
        bus.cs_enc_dec = 1'b1;

        // Timeout: no core_done, err rises after 1024 WAIT cycles
        o0 = oclk_cnt;
        waited = 0;
        while (bus.err !== 1'b1 && waited < 2000) begin
            tick();
            waited++;
        end
        chk("to_err", 128'(bus.err), 1);
        chk("to_latency", 128'(waited), 1025);
        bus.core_done   = 1'b1;
        bus.core_result = res2;
        tick();
        bus.core_done   = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("to_no_oclk", 128'(oclk_cnt - o0), 0);
        chk("to_err_sticky", 128'(bus.err), 1);

        // Reset in the middle of TX at bit 40
        send_bits(msg3, key1, FB, -1);
        chk("rtx_start", 128'(bus.core_start), 1);
        bus.cs_enc_dec = 1'b1;
        tick();
        tick();
        bus.core_done   = 1'b1;
        bus.core_result = res2;
        tick();
        bus.core_done   = 1'b0;
        for (int i = 1; i <= 40; i++) tick();
        chk("rtx_bit40", 128'(bus.Miso), 128'(res2[MSG_W-1-40]));
        chk("rtx_oclk40", 128'(bus.Out_clk), 1);
        rst_n = 1'b0;
        #1;
        chk("rtx_miso", 128'(bus.Miso), 0);
        chk("rtx_oclk", 128'(bus.Out_clk), 0);
        chk("rtx_err", 128'(bus.err), 0);
        chk("rtx_msg", bus.core_msg, 0);
        chk("rtx_key", 128'(|bus.core_key), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Frame after reset, then select held low throughout (re-arm rule)
        send_bits(msg3, key2, FB, -1);
        chk("post_rst_start", 128'(bus.core_start), 1);
        chk("post_rst_msg", bus.core_msg, msg3);
        tick();
        tick();
        bus.core_done   = 1'b1;
        bus.core_result = res1;
        tick();
        bus.core_done   = 1'b0;
        capture_tx(got, n_oc);
        chk("rearm_tx_data", got, res1);
        s0 = start_cnt;
        o0 = oclk_cnt;
        for (int k = 0; k < int'(FB) + 100; k++) begin
            bus.Mosi = 1'($urandom);
            tick();
        end
        chk("rearm_no_start", 128'(start_cnt - s0), 0);
        chk("rearm_no_oclk", 128'(oclk_cnt - o0), 0);
        chk("rearm_msg_hold", bus.core_msg, msg3);
        bus.cs_enc_dec = 1'b1;
        tick();
        send_bits(msg1, key2, FB, -1);
        chk("rearm_start", 128'(bus.core_start), 1);
        chk("rearm_msg", bus.core_msg, msg1);
        bus.cs_enc_dec = 1'b1;
        for (int k = 0; k < 1100; k++) tick();

`ifdef FRAME_PARITY_EN
        // Parity: one flipped data bit is rejected, a clean frame is accepted
        chk("par_err_pre", 128'(bus.err), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        s0 = start_cnt;
        send_bits(msg2, key1, FB, 5);
        tick();
        chk("par_bad_no_start", 128'(start_cnt - s0), 0);
        chk("par_bad_err", 128'(bus.err), 1);
        chk("par_bad_msg", bus.core_msg, 0);
        bus.cs_enc_dec = 1'b1;
        tick();
        send_bits(msg2, key1, FB, -1);
        chk("par_ok_start", 128'(bus.core_start), 1);
        chk("par_ok_msg", bus.core_msg, msg2);
        bus.cs_enc_dec = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
